fast_sdram_model: RTL and testbench
===================================

// Module: fast_sdram_model
// PURPOSE
//  Fast, fixed-latency behavioural main memory for the MIPS core simulation. Serves three
//  independent burst channels (I-cache read, D-cache read, D-cache write) from one word array
//  named `mem`, which benches preload with $readmemh. Functional only: no timing accuracy.
// PARAMETERS
//  DELAY       20     cycles from burst accept to first data beat / first write slot
//  DEPTH       2**20  number of 32-bit words in mem
//  ADDR_WIDTH  26     byte-address width of base inputs
//  LEN_WIDTH   8      burst-length field width (words)
// PORTS
//  clk                   in   1    clock; all logic on posedge
//  rst                   in   1    synchronous, active-high reset
//  ir_go, dr_go          in   1    start read burst (I / D channel)
//  ir_base, dr_base      in   AW   byte base address; bits [1:0] ignored
//  ir_len, dr_len        in   LW   burst length in words
//  ir_pop, dr_pop        in   1    consumer takes current beat
//  ir_avail, dr_avail    out  1    current beat valid
//  ir_data, dr_data      out  32   current beat data
//  ir_done, dr_done      out  1    1-cycle pulse: burst finished
//  dw_go/dw_base/dw_len  in   1/AW/LW  start write burst
//  dw_push, dw_wdata     in   1/32 producer writes one word
//  dw_full               out  1    1 = cannot accept dw_push
//  dw_done               out  1    1-cycle pulse: write burst finished
// BEHAVIOUR
//  - Reset: all channels IDLE; avail=0, data=0, done=0, dw_full=1; mem contents preserved.
//  - Each channel FSM: IDLE -> WAIT (DELAY cycles) -> XFER -> DONE(1 cycle) -> IDLE.
//  - go sampled only in IDLE; go in any other state ignored. base/len latched on accept.
//  - Word index = (base>>2 + k) mod DEPTH (wrap-around, no error).
//  - Read XFER: avail=1, data=mem[idx(k)]; pop with avail advances k next cycle; pop with
//    avail=0 ignored. After len pops -> DONE: done=1, avail=0.
//  - Write XFER: dw_full=0; dw_push stores dw_wdata at idx(k) on that edge, k++. After len
//    pushes -> DONE, dw_full=1. dw_full=1 in IDLE, WAIT, DONE; pushes then dropped.
//  - First beat/slot appears exactly DELAY cycles after the go edge (go at edge 0 ->
//    avail/!full visible after edge DELAY). DELAY=0 means next cycle.
//  - len=0: WAIT then DONE directly; no beats, no mem writes.
//  - Channels fully concurrent, no arbitration. Same-word write and read beat in one cycle:
//    read returns pre-write value; new value visible next cycle.
//  - rst mid-burst: abort immediately to IDLE, no done pulse, writes already done persist.
// CONFIGURATION
//  FAST_SDRAM_TRACE_EN defined: $display per accepted burst (channel, base, len, time) and
//  per write word (addr, data). Undefined: no display code; behaviour identical otherwise.
// STRUCTURE
//  Package mips_mem_pkg: ADDR_WIDTH, LEN_WIDTH, DATA_WIDTH=32, chan_state_e {IDLE,WAIT,XFER,DONE}.
//  Sub-module fast_sdram_chan: FSM + delay/beat counters + index gen, instantiated 3x
//  (mode param READ/WRITE); top owns `mem` and the read/write muxing.
// TESTING
//  1. mem[0..3]=1,2,3,4; ir_go base=0 len=4, pop always -> avail rises DELAY cycles later,
//     data 1,2,3,4 on consecutive cycles, ir_done one cycle after 4th pop.
//  2. dw_go base=0x40 len=2, push 0xDEAD,0xBEEF when !full -> dr burst base=0x40 len=2
//     returns 0xDEAD,0xBEEF; dw_done pulses once.
//  3. Read with pop held low 5 cycles after avail -> data stable at mem[idx0], no advance.
//  4. ir and dr bursts started same cycle to different addresses -> both complete in
//     DELAY+len+1 cycles with correct data; second go during busy ignored.
//  5. base=(DEPTH-1)*4 len=2 -> data mem[DEPTH-1], mem[0] (wrap).
//  6. rst asserted mid-XFER -> next cycle avail=0, done never pulses, dw_full=1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared widths and channel types for the fast behavioural SDRAM model.
package mips_mem_pkg;

  localparam int unsigned ADDR_WIDTH = 26;
  localparam int unsigned LEN_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} chan_state_e;

  typedef enum logic {MODE_READ, MODE_WRITE} chan_mode_e;

endpackage

// File: rtl/fast_sdram_chan.sv
// One burst channel: accept, fixed delay, beat counting and word-index generation.
// With FAST_SDRAM_TRACE_EN defined, each accepted burst is printed.
module fast_sdram_chan
  import mips_mem_pkg::*;
#(
  parameter chan_mode_e  MODE  = MODE_READ,
  parameter int unsigned DELAY = 20,
  parameter int unsigned DEPTH = 2**20,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  advance_i,
  output logic                  flag_o,
  output logic                  done_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;

  chan_state_e          state_q, state_d;
  logic [31:0]          dly_q, dly_d;
  logic [WORD_W-1:0]    base_q, base_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] k_q, k_d;
  logic                 flag_q, flag_d;
  logic                 done_q, done_d;
  logic [31:0]          word_sum;
  logic                 unused_base_lsb;

  assign unused_base_lsb = ^base_i[1:0];

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    base_d  = base_q;
    len_d   = len_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          base_d = base_i[ADDR_WIDTH-1:2];
          len_d  = len_i;
          k_d    = '0;
          if (DELAY == 0) begin
            state_d = (len_i == '0) ? DONE : XFER;
          end else begin
            state_d = WAIT;
            dly_d   = DELAY - 1;
          end
        end
      end
      WAIT: begin
        if (dly_q == '0) begin
          state_d = (len_q == '0) ? DONE : XFER;
        end else begin
          dly_d = dly_q - 1;
        end
      end
      XFER: begin
        if (advance_i) begin
          k_d = k_q + 1'b1;
          if ((k_q + 1'b1) == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Read channels flag "beat available"; write channels flag "full".
    flag_d = (MODE == MODE_WRITE) ? (state_d != XFER) : (state_d == XFER);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dly_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      flag_q  <= (MODE == MODE_WRITE);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      base_q  <= base_d;
      len_q   <= len_d;
      k_q     <= k_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
    end
  end

  assign word_sum = 32'(base_q) + 32'(k_q);
  assign idx_o    = IDX_W'(word_sum % DEPTH);
  assign flag_o   = flag_q;
  assign done_o   = done_q;

`ifdef FAST_SDRAM_TRACE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == IDLE && go_i) begin
      $display("%0t fast_sdram %s burst base=0x%h len=%0d", $time,
               (MODE == MODE_WRITE) ? "write" : "read", base_i, len_i);
    end
  end
`endif

endmodule

// File: rtl/fast_sdram_model.sv
// Fixed-latency behavioural main memory with I-read, D-read and D-write burst channels.
// Define FAST_SDRAM_TRACE_EN to print accepted bursts and written words.
module fast_sdram_model
  import mips_mem_pkg::*;
#(
  parameter int unsigned DELAY = 20,
  parameter int unsigned DEPTH = 2**20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_go,
  input  logic [ADDR_WIDTH-1:0] ir_base,
  input  logic [LEN_WIDTH-1:0]  ir_len,
  input  logic                  ir_pop,
  output logic                  ir_avail,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  ir_done,
  input  logic                  dr_go,
  input  logic [ADDR_WIDTH-1:0] dr_base,
  input  logic [LEN_WIDTH-1:0]  dr_len,
  input  logic                  dr_pop,
  output logic                  dr_avail,
  output logic [DATA_WIDTH-1:0] dr_data,
  output logic                  dr_done,
  input  logic                  dw_go,
  input  logic [ADDR_WIDTH-1:0] dw_base,
  input  logic [LEN_WIDTH-1:0]  dw_len,
  input  logic                  dw_push,
  input  logic [DATA_WIDTH-1:0] dw_wdata,
  output logic                  dw_full,
  output logic                  dw_done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      ir_idx, dr_idx, dw_idx;
  logic                  dw_wen;

  fast_sdram_chan #(.MODE(MODE_READ), .DELAY(DELAY), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ir (
    .clk_i    (clk),
    .rst_i    (rst),
    .go_i     (ir_go),
    .base_i   (ir_base),
    .len_i    (ir_len),
    .advance_i(ir_pop),
    .flag_o   (ir_avail),
    .done_o   (ir_done),
    .idx_o    (ir_idx)
  );

  fast_sdram_chan #(.MODE(MODE_READ), .DELAY(DELAY), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dr (
    .clk_i    (clk),
    .rst_i    (rst),
    .go_i     (dr_go),
    .base_i   (dr_base),
    .len_i    (dr_len),
    .advance_i(dr_pop),
    .flag_o   (dr_avail),
    .done_o   (dr_done),
    .idx_o    (dr_idx)
  );

  fast_sdram_chan #(.MODE(MODE_WRITE), .DELAY(DELAY), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dw (
    .clk_i    (clk),
    .rst_i    (rst),
    .go_i     (dw_go),
    .base_i   (dw_base),
    .len_i    (dw_len),
    .advance_i(dw_push),
    .flag_o   (dw_full),
    .done_o   (dw_done),
    .idx_o    (dw_idx)
  );

  // Reads are combinational off the array, so a same-cycle write shows up one cycle later.
  assign ir_data = ir_avail ? mem[ir_idx] : '0;
  assign dr_data = dr_avail ? mem[dr_idx] : '0;
  assign dw_wen  = dw_push && !dw_full && !rst;

  always_ff @(posedge clk) begin
    if (dw_wen) begin
      mem[dw_idx] <= dw_wdata;
    end
  end

`ifdef FAST_SDRAM_TRACE_EN
  always_ff @(posedge clk) begin
    if (dw_wen) begin
      $display("%0t fast_sdram write word addr=0x%h data=0x%h", $time, dw_idx, dw_wdata);
    end
  end
`endif

endmodule

// File: tb/tb_fast_sdram_model.sv
// Self-checking bench for fast_sdram_model: vector table, hand sequences, randomized bursts.
module tb_fast_sdram_model;
  import mips_mem_pkg::*;

  localparam int unsigned D     = 20;
  localparam int unsigned DEPTH = 2**20;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_go, ir_pop, ir_avail, ir_done;
  logic [25:0] ir_base;
  logic [7:0]  ir_len;
  logic [31:0] ir_data;
  logic        dr_go, dr_pop, dr_avail, dr_done;
  logic [25:0] dr_base;
  logic [7:0]  dr_len;
  logic [31:0] dr_data;
  logic        dw_go, dw_push, dw_full, dw_done;
  logic [25:0] dw_base;
  logic [7:0]  dw_len;
  logic [31:0] dw_wdata;

  fast_sdram_model #(.DELAY(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ir_go(ir_go), .ir_base(ir_base), .ir_len(ir_len), .ir_pop(ir_pop),
    .ir_avail(ir_avail), .ir_data(ir_data), .ir_done(ir_done),
    .dr_go(dr_go), .dr_base(dr_base), .dr_len(dr_len), .dr_pop(dr_pop),
    .dr_avail(dr_avail), .dr_data(dr_data), .dr_done(dr_done),
    .dw_go(dw_go), .dw_base(dw_base), .dw_len(dw_len), .dw_push(dw_push),
    .dw_wdata(dw_wdata), .dw_full(dw_full), .dw_done(dw_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int unsigned];

  typedef struct {
    bit          dch;
    logic [25:0] base;
    logic [7:0]  len;
    int          stall;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned widx(input logic [25:0] base, input int k);
    return (int'(base >> 2) + k) % DEPTH;
  endfunction

  function automatic logic get_avail(input bit dch);
    return dch ? dr_avail : ir_avail;
  endfunction

  function automatic logic get_done(input bit dch);
    return dch ? dr_done : ir_done;
  endfunction

  function automatic logic [31:0] get_data(input bit dch);
    return dch ? dr_data : ir_data;
  endfunction

  task automatic set_go(input bit dch, input bit v, input logic [25:0] base, input logic [7:0] len);
    if (dch) begin dr_go = v; dr_base = base; dr_len = len; end
    else begin ir_go = v; ir_base = base; ir_len = len; end
  endtask

  task automatic set_pop(input bit dch, input bit v);
    if (dch) dr_pop = v;
    else ir_pop = v;
  endtask

  task automatic read_burst(input bit dch, input logic [25:0] base, input logic [7:0] len,
                            input int stall, input bit rand_pop,
                            output logic [31:0] first, output logic [31:0] last);
    int c;
    int k;
    int st;
    bit p;
    first = '0;
    last  = '0;
    st    = stall;
    @(negedge clk);
    set_go(dch, 1'b1, base, len);
    @(negedge clk);
    set_go(dch, 1'b0, base, len);
    c = 0;
    while (!get_avail(dch) && !get_done(dch) && c < int'(D) + 50) begin
      @(negedge clk);
      c++;
    end
    chk("read latency", c, D);
    k = 0;
    c = 0;
    while (k < int'(len) && c < 1000) begin
      chk("read avail", get_avail(dch), 1);
      chk("read data", get_data(dch), model[widx(base, k)]);
      if (k == 0) first = get_data(dch);
      last = get_data(dch);
      if (k == 0 && st > 0) begin
        p = 1'b0;
        st--;
      end else begin
        p = rand_pop ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      set_pop(dch, p);
      @(negedge clk);
      set_pop(dch, 1'b0);
      c++;
      if (p) k++;
    end
    chk("read done pulse", get_done(dch), 1);
    chk("read avail after done", get_avail(dch), 0);
    @(negedge clk);
    chk("read done single", get_done(dch), 0);
  endtask

  task automatic write_burst(input logic [25:0] base, input logic [7:0] len,
                             input bit fixed, input bit rand_push);
    int c;
    int k;
    bit p;
    @(negedge clk);
    dw_go = 1'b1; dw_base = base; dw_len = len;
    @(negedge clk);
    dw_go = 1'b0;
    c = 0;
    while (dw_full && !dw_done && c < int'(D) + 50) begin
      @(negedge clk);
      c++;
    end
    chk("write latency", c, D);
    k = 0;
    c = 0;
    while (k < int'(len) && c < 1000) begin
      chk("write full", dw_full, 0);
      p = rand_push ? ($urandom_range(0, 2) != 0) : 1'b1;
      dw_push  = p;
      dw_wdata = fixed ? ((k == 0) ? 32'h0000_DEAD : 32'h0000_BEEF) : $urandom;
      if (p) model[widx(base, k)] = dw_wdata;
      @(negedge clk);
      dw_push = 1'b0;
      c++;
      if (p) k++;
    end
    chk("write done pulse", dw_done, 1);
    chk("write full after", dw_full, 1);
    dw_push  = 1'b1;
    dw_wdata = 32'hBAD0_0BAD;
    @(negedge clk);
    dw_push = 1'b0;
    chk("write done single", dw_done, 0);
    chk("write full idle", dw_full, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f, l, old;
    int c;
    int n_done;
    int n_avail;
    rst = 1'b1;
    ir_go = 0; ir_base = '0; ir_len = '0; ir_pop = 0;
    dr_go = 0; dr_base = '0; dr_len = '0; dr_pop = 0;
    dw_go = 0; dw_base = '0; dw_len = '0; dw_push = 0; dw_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      dut.mem[i] = 32'(i + 1);
      model[i]   = 32'(i + 1);
    end
    for (int j = 0; j < 16; j++) begin
      dut.mem[DEPTH - 1 - j] = 32'hF000_0000 + 32'(j);
      model[DEPTH - 1 - j]   = 32'hF000_0000 + 32'(j);
    end

    vecs[0] = '{1'b0, 26'h0,       8'd4, 0, 32'd1,        32'd4};
    vecs[1] = '{1'b1, 26'h10,      8'd3, 0, 32'd5,        32'd7};
    vecs[2] = '{1'b0, 26'h3FFFFFC, 8'd2, 0, 32'hF0000000, 32'd1};
    vecs[3] = '{1'b1, 26'h3FFFFF8, 8'd3, 0, 32'hF0000001, 32'd1};
    vecs[4] = '{1'b0, 26'h13,      8'd1, 0, 32'd5,        32'd5};
    vecs[5] = '{1'b1, 26'h24,      8'd2, 5, 32'd10,       32'd11};
    vecs[6] = '{1'b0, 26'h30,      8'd0, 0, 32'd0,        32'd0};

    repeat (2) @(negedge clk);
    chk("reset ir_avail", ir_avail, 0);
    chk("reset ir_data", ir_data, 0);
    chk("reset ir_done", ir_done, 0);
    chk("reset dr_avail", dr_avail, 0);
    chk("reset dr_data", dr_data, 0);
    chk("reset dw_full", dw_full, 1);
    chk("reset dw_done", dw_done, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      read_burst(vecs[i].dch, vecs[i].base, vecs[i].len, vecs[i].stall, 1'b0, f, l);
      chk($sformatf("vec%0d first", i), f, vecs[i].exp_first);
      chk($sformatf("vec%0d last", i), l, vecs[i].exp_last);
    end

    write_burst(26'h40, 8'd2, 1'b1, 1'b0);
    read_burst(1'b1, 26'h40, 8'd2, 0, 1'b0, f, l);
    chk("wr/rd first", f, 32'h0000_DEAD);
    chk("wr/rd last", l, 32'h0000_BEEF);
    write_burst(26'h60, 8'd0, 1'b0, 1'b0);

    // Concurrent I/D reads; a second ir_go while busy must be ignored.
    @(negedge clk);
    ir_go = 1; ir_base = 26'h20; ir_len = 3;
    dr_go = 1; dr_base = 26'h80; dr_len = 3;
    @(negedge clk);
    ir_go = 0; dr_go = 0; ir_pop = 1; dr_pop = 1;
    for (int cc = 0; cc < 2 * int'(D) + 10; cc++) begin
      if (cc == 5) begin ir_go = 1; ir_base = 26'h0; ir_len = 8'd1; end
      if (cc == 6) ir_go = 0;
      chk("conc ir_avail", ir_avail, (cc >= int'(D) && cc < int'(D) + 3));
      chk("conc dr_avail", dr_avail, (cc >= int'(D) && cc < int'(D) + 3));
      chk("conc ir_done", ir_done, (cc == int'(D) + 3));
      chk("conc dr_done", dr_done, (cc == int'(D) + 3));
      if (cc >= int'(D) && cc < int'(D) + 3) begin
        chk("conc ir_data", ir_data, model[8 + cc - int'(D)]);
        chk("conc dr_data", dr_data, model[32 + cc - int'(D)]);
      end
      @(negedge clk);
    end
    ir_pop = 0; dr_pop = 0;

    // Same-word write and read beat in one cycle.
    @(negedge clk);
    dw_go = 1; dw_base = 26'h100; dw_len = 1;
    dr_go = 1; dr_base = 26'h100; dr_len = 1;
    @(negedge clk);
    dw_go = 0; dr_go = 0;
    c = 0;
    while (!dr_avail && c < int'(D) + 50) begin @(negedge clk); c++; end
    chk("same-word latency", c, D);
    chk("same-word full", dw_full, 0);
    old = model[64];
    chk("same-word old data", dr_data, old);
    dw_push = 1; dw_wdata = 32'h1234_5678;
    model[64] = 32'h1234_5678;
    @(negedge clk);
    dw_push = 0;
    chk("same-word new data", dr_data, 32'h1234_5678);
    chk("same-word dw_done", dw_done, 1);
    dr_pop = 1;
    @(negedge clk);
    dr_pop = 0;
    chk("same-word dr_done", dr_done, 1);
    @(negedge clk);

    // Reset in the middle of transfers.
    @(negedge clk);
    dw_go = 1; dw_base = 26'h200; dw_len = 4;
    ir_go = 1; ir_base = 26'h8; ir_len = 4;
    @(negedge clk);
    dw_go = 0; ir_go = 0;
    c = 0;
    while (!ir_avail && c < int'(D) + 50) begin @(negedge clk); c++; end
    chk("rst-test latency", c, D);
    dw_push = 1; dw_wdata = 32'hCAFE_0001; ir_pop = 1;
    model[128] = 32'hCAFE_0001;
    @(negedge clk);
    rst = 1; dw_wdata = 32'h5555_5555;
    @(negedge clk);
    rst = 0; dw_push = 0; ir_pop = 0;
    chk("rst ir_avail", ir_avail, 0);
    chk("rst ir_data", ir_data, 0);
    chk("rst dw_full", dw_full, 1);
    n_done = 0;
    n_avail = 0;
    for (int cc = 0; cc < int'(D) + 10; cc++) begin
      if (ir_done || dw_done) n_done++;
      if (ir_avail || !dw_full) n_avail++;
      @(negedge clk);
    end
    chk("rst no done pulse", n_done, 0);
    chk("rst stays idle", n_avail, 0);
    read_burst(1'b1, 26'h200, 8'd2, 0, 1'b0, f, l);
    chk("rst write persisted", f, 32'hCAFE_0001);
    chk("rst push dropped", l, 32'd130);

    // Randomized bursts against the reference array.
    for (int it = 0; it < 14; it++) begin
      int unsigned w;
      logic [25:0] b;
      w = $urandom_range(0, 250);
      b = 26'(w * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: read_burst(1'b0, b, 8'($urandom_range(0, 5)), 0, 1'b1, f, l);
        1: read_burst(1'b1, b, 8'($urandom_range(0, 5)), 0, 1'b1, f, l);
        default: write_burst(b, 8'($urandom_range(1, 5)), 1'b0, 1'b1);
      endcase
    end
    read_burst(1'b0, 26'h0, 8'd255, 0, 1'b1, f, l);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
